cycle_sequencer: RTL

- Generates the one-hot T-step and M-cycle counters that drive every control-unit decoder (X0..X3 and the microcode blocks).
- Acts on the decoders' end-of-instruction strobes (fetch, reset-cycle, CB prefix, EI/DI, HALT).
- Owns the opcode register, CB-mode flag, IME with EI delay, HALT state and interrupt-dispatch entry.
- Sits between the bus/fetch path and the control-unit decoders.

---
 rtl/cu_pkg.sv | 18 +
 rtl/ime_controller.sv | 53 +++++
 rtl/cycle_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared constants for the control-unit sequencing logic:
// one-hot step/M-cycle encodings and well-known opcodes.
package cu_pkg;

  localparam int STEPS_PER_MCYCLE = 4;
  localparam int MAX_MCYCLES      = 8;

  localparam logic [STEPS_PER_MCYCLE-1:0] STEP_T1 = 4'b0001;
  localparam logic [STEPS_PER_MCYCLE-1:0] STEP_T2 = 4'b0010;
  localparam logic [STEPS_PER_MCYCLE-1:0] STEP_T3 = 4'b0100;
  localparam logic [STEPS_PER_MCYCLE-1:0] STEP_T4 = 4'b1000;

  localparam logic [MAX_MCYCLES-1:0] COUNT_M1 = 8'h01;

  localparam logic [7:0] OPC_NOP = 8'h00;
  localparam logic [7:0] OPC_CB  = 8'hCB;

endpackage

// File: rtl/ime_controller.sv
// Interrupt master enable with one-instruction EI delay;
// DI and dispatch entry both cancel any pending EI.
module ime_controller
  import cu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_bnd,
  input  logic i_fetch_bnd,
  input  logic i_cb,
  input  logic i_ei,
  input  logic i_di,
  input  logic i_take,
  output logic o_ime,
  output logic o_ei_promote,
  output logic o_ime_eff
);

  logic ime_q, ime_d;
  logic pend_q, pend_d;

  assign o_ei_promote = pend_q & ~i_cb;
  assign o_ime_eff    = ime_q | o_ei_promote;
  assign o_ime        = ime_q;

  always_comb begin
    ime_d  = ime_q;
    pend_d = pend_q;
    if (i_bnd) begin
      if (i_take | i_di) begin
        ime_d  = 1'b0;
        pend_d = 1'b0;
      end else begin
        if (i_fetch_bnd & o_ei_promote) begin
          ime_d  = 1'b1;
          pend_d = 1'b0;
        end
        if (i_ei) pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ime_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ime_q  <= ime_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// T-step / M-cycle sequencer: opcode register, CB mode,
// HALT and interrupt-dispatch entry for the control unit.
module cycle_sequencer
  import cu_pkg::*;
(
  input  logic                        i_Clk,
  input  logic                        i_Reset_n,
  input  logic                        i_Enable,
  input  logic                        i_Fetch,
  input  logic                        i_Reset_Cycle,
  input  logic                        i_CB_Prefix,
  input  logic                        i_EI,
  input  logic                        i_DI,
  input  logic                        i_Halt,
  input  logic                        i_IRQ_Pending,
  input  logic [7:0]                  i_Data_Bus,
  output logic [STEPS_PER_MCYCLE-1:0] o_Cycle_Step,
  output logic [MAX_MCYCLES-1:0]      o_Cycle_Count,
  output logic [7:0]                  o_Opcode,
  output logic                        o_CB_Mode,
  output logic                        o_IME,
  output logic                        o_Int_Dispatch,
  output logic                        o_Halted,
  output logic                        o_Decode_Active,
  output logic                        o_Overrun
);

  logic [STEPS_PER_MCYCLE-1:0] step_q, step_d;
  logic [MAX_MCYCLES-1:0]      count_q, count_d;
  logic [7:0]                  opcode_q, opcode_d;
  logic cb_q, cb_d;
  logic disp_q, disp_d;
  logic halted_q, halted_d;
  logic ovr_q, ovr_d;

  logic bnd, fetch_bnd, halt_stop;
  logic take_halt, take_fetch, take;
  logic ime, ei_promote, ime_eff;

  assign bnd        = i_Enable & step_q[STEPS_PER_MCYCLE-1];
  assign fetch_bnd  = bnd & ~halted_q & i_Fetch;
  assign halt_stop  = i_Halt & ~i_IRQ_Pending;
  assign take_halt  = halted_q & i_IRQ_Pending & ime;
  assign take_fetch = ~halted_q & i_Fetch & ~halt_stop
                    & ime_eff & i_IRQ_Pending & ~i_CB_Prefix;
  assign take       = bnd & (take_halt | take_fetch);

  ime_controller u_ime (
    .clk          (i_Clk),
    .rst_n        (i_Reset_n),
    .i_bnd        (bnd),
    .i_fetch_bnd  (fetch_bnd),
    .i_cb         (i_CB_Prefix),
    .i_ei         (i_EI),
    .i_di         (i_DI),
    .i_take       (take),
    .o_ime        (ime),
    .o_ei_promote (ei_promote),
    .o_ime_eff    (ime_eff)
  );

  always_comb begin
    step_d   = step_q;
    count_d  = count_q;
    opcode_d = opcode_q;
    cb_d     = cb_q;
    disp_d   = disp_q;
    halted_d = halted_q;
    ovr_d    = ovr_q;
    if (i_Enable)
      step_d = {step_q[STEPS_PER_MCYCLE-2:0],
                step_q[STEPS_PER_MCYCLE-1]};
    if (bnd) begin
      if (halted_q) begin
        count_d = COUNT_M1;
        if (i_IRQ_Pending) begin
          halted_d = 1'b0;
          if (ime) disp_d   = 1'b1;
          else     opcode_d = i_Data_Bus;
        end
      end else if (i_Fetch) begin
        count_d = COUNT_M1;
        disp_d  = 1'b0;
        cb_d    = i_CB_Prefix & ~take_fetch;
        if (halt_stop)       halted_d = 1'b1;
        else if (take_fetch) disp_d   = 1'b1;
        else                 opcode_d = i_Data_Bus;
      end else if (i_Reset_Cycle) begin
        count_d = COUNT_M1;
      end else begin
        count_d = {count_q[MAX_MCYCLES-2:0],
                   count_q[MAX_MCYCLES-1]};
        if (count_q[MAX_MCYCLES-1]) ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      step_q   <= STEP_T1;
      count_q  <= COUNT_M1;
      opcode_q <= OPC_NOP;
      cb_q     <= 1'b0;
      disp_q   <= 1'b0;
      halted_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      step_q   <= step_d;
      count_q  <= count_d;
      opcode_q <= opcode_d;
      cb_q     <= cb_d;
      disp_q   <= disp_d;
      halted_q <= halted_d;
      ovr_q    <= ovr_d;
    end
  end

  assign o_Cycle_Step    = step_q;
  assign o_Cycle_Count   = count_q;
  assign o_Opcode        = opcode_q;
  assign o_CB_Mode       = cb_q;
  assign o_IME           = ime;
  assign o_Int_Dispatch  = disp_q;
  assign o_Halted        = halted_q;
  assign o_Decode_Active = ~halted_q;
  assign o_Overrun       = ovr_q;

endmodule
